// File: rtl/i2c_reg_target.sv
// I2C target with a 7-bit address and a byte-wide register port of 2^REG_AW entries.
// The pointer auto-increments with wrap. Repeated START keeps the pointer, so pointer-then-read works.
module i2c_reg_target #(
    parameter logic [6:0]  I2C_ADDRESS = 7'h49,
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [REG_AW-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              rd_en,
    output logic              busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
    } state_e;

    localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1);

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;
    state_e                 r_state, w_state_nxt;
    logic [3:0]             r_bit_cnt, w_cnt_nxt;
    logic [6:0]             r_rx, w_rx_nxt;
    logic [6:0]             r_tx, w_tx_nxt;
    logic [REG_AW-1:0]      r_ptr, w_ptr_nxt;
    logic                   r_rw, w_rw_nxt;
    logic                   r_flag, w_flag_nxt;
    logic                   r_nack, w_nack_nxt;
    logic                   r_sda_oe, w_oe_nxt;
    logic                   r_wr_en, w_wr_en_nxt;
    logic [REG_AW-1:0]      r_wr_addr, w_wr_addr_nxt;
    logic [7:0]             r_wr_data, w_wr_data_nxt;
    logic                   r_rd_en, w_rd_en_nxt;
    logic                   r_busy, w_busy_nxt;

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    // Synchronisers reset to 1 (idle bus) so reset release never fakes an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // START/STOP need SCL high on both sides, so a simultaneous SCL rise is a data bit.
    assign w_start    = r_sda_prev & ~w_sda & r_scl_prev & w_scl;
    assign w_stop     = ~r_sda_prev & w_sda & r_scl_prev & w_scl;
    assign w_byte     = {r_rx, w_sda};

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_bit_cnt;
        w_rx_nxt      = r_rx;
        w_tx_nxt      = r_tx;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_flag_nxt    = r_flag;
        w_nack_nxt    = r_nack;
        w_oe_nxt      = r_sda_oe;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_rd_en_nxt   = 1'b0;
        w_busy_nxt    = r_busy;

        if (w_stop) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = 4'd0;
            w_flag_nxt  = 1'b0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = StAddr;
            w_cnt_nxt   = 4'd0;
            w_flag_nxt  = 1'b0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                StAddr, StPtr, StWdata: begin
                    if (w_scl_rise) begin
                        w_rx_nxt  = w_byte[6:0];
                        w_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_cnt_nxt = 4'd0;
                            if (r_state == StAddr) begin
                                if (w_byte[7:1] == I2C_ADDRESS) begin
                                    w_state_nxt = StAddrAck;
                                    w_busy_nxt  = 1'b1;
                                    w_rw_nxt    = w_byte[0];
                                end else begin
                                    w_state_nxt = StIgnore;
                                    w_busy_nxt  = 1'b0;
                                end
                            end else if (r_state == StPtr) begin
                                w_ptr_nxt   = w_byte[REG_AW-1:0];
                                w_state_nxt = StPtrAck;
                            end else begin
                                w_wr_en_nxt   = 1'b1;
                                w_wr_addr_nxt = r_ptr;
                                w_wr_data_nxt = w_byte;
                                w_ptr_nxt     = r_ptr + PTR_ONE;
                                w_state_nxt   = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    // r_flag marks that the ACK slot is open; the next SCL fall closes it.
                    if (w_scl_fall) begin
                        if (!r_flag) begin
                            w_flag_nxt = 1'b1;
                            w_oe_nxt   = 1'b1;
                        end else begin
                            w_flag_nxt = 1'b0;
                            w_oe_nxt   = 1'b0;
                            w_cnt_nxt  = 4'd0;
                            if (r_state == StAddrAck && r_rw) begin
                                w_state_nxt = StRdata;
                                w_tx_nxt    = rd_data[6:0];
                                w_oe_nxt    = ~rd_data[7];
                                w_rd_en_nxt = 1'b1;
                            end else if (r_state == StAddrAck) begin
                                w_state_nxt = StPtr;
                            end else begin
                                w_state_nxt = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = StRdataAck;
                        end else begin
                            w_oe_nxt = ~r_tx[6];
                            w_tx_nxt = {r_tx[5:0], 1'b0};
                        end
                    end
                end
                StRdataAck: begin
                    if (w_scl_rise) begin
                        w_nack_nxt = w_sda;
                        w_flag_nxt = 1'b1;
                        w_ptr_nxt  = r_ptr + PTR_ONE;
                    end else if (w_scl_fall && r_flag) begin
                        w_flag_nxt = 1'b0;
                        if (r_nack) begin
                            w_state_nxt = StIgnore;
                        end else begin
                            w_state_nxt = StRdata;
                            w_tx_nxt    = rd_data[6:0];
                            w_oe_nxt    = ~rd_data[7];
                            w_rd_en_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_bit_cnt <= 4'd0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_flag    <= 1'b0;
            r_nack    <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_rx      <= w_rx_nxt;
            r_tx      <= w_tx_nxt;
            r_ptr     <= w_ptr_nxt;
            r_rw      <= w_rw_nxt;
            r_flag    <= w_flag_nxt;
            r_nack    <= w_nack_nxt;
            r_sda_oe  <= w_oe_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign sda_oe  = r_sda_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_addr = r_ptr;
    assign rd_en   = r_rd_en;
    assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bit-banged I2C master with an external register bank.
// Byte-level reference model holds register contents and the pointer.
module tb_i2c_reg_target;

    localparam int Q = 50;  // quarter SCL bit, ns (bit = 20 system clocks)

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_en, rd_en, busy;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    logic [7:0] bank [16];
    logic       tb_wr = 1'b0;
    logic [3:0] tb_waddr = 4'd0;
    logic [7:0] tb_wdata = 8'd0;

    logic [7:0]  ref_mem [16];
    logic [3:0]  ref_ptr = 4'd0;
    logic [11:0] wq[$];
    logic [11:0] exp_wq[$];
    logic [7:0]  wbuf [8];
    int          oe_cnt = 0, rd_cnt = 0;
    int          n_cmp = 0, n_err = 0;

    always #5 clock = ~clock;
    assign sda_line = sda_m & ~sda_oe;

    i2c_reg_target #(.I2C_ADDRESS(7'h49), .REG_AW(4), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_en(rd_en), .busy(busy)
    );

    always @(posedge clock) begin
        if (wr_en) bank[wr_addr] <= wr_data;
        else if (tb_wr) bank[tb_waddr] <= tb_wdata;
        if (wr_en) wq.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end
    assign rd_data = bank[rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        repeat (8) @(posedge clock);
        #2;
    endtask

    task automatic tb_set(input logic [3:0] a, input logic [7:0] d);
        tb_waddr = a; tb_wdata = d; tb_wr = 1'b1;
        @(posedge clock); #2;
        tb_wr = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_line; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(nack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
    endtask

    task automatic check_writes();
        chk("wr_count", wq.size(), exp_wq.size());
        for (int i = 0; i < wq.size() && i < exp_wq.size(); i++) chk("wr_entry", wq[i], exp_wq[i]);
    endtask

    task automatic txn_write(input logic [6:0] addr, input logic [7:0] ptr, input int n);
        logic       nack, match;
        logic [3:0] p;
        int         oe0;
        match = (addr == 7'h49);
        wq.delete(); exp_wq.delete();
        oe0 = oe_cnt;
        i2c_start();
        write_byte({addr, 1'b0}, nack);
        chk("addr_ack", nack, !match);
        chk("busy_addr", busy, match);
        write_byte(ptr, nack);
        chk("ptr_ack", nack, !match);
        p = ptr[3:0];
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i], nack);
            chk("data_ack", nack, !match);
            if (match) begin
                ref_mem[p] = wbuf[i];
                exp_wq.push_back({p, wbuf[i]});
                p = p + 4'd1;
            end
        end
        if (match) ref_ptr = p;
        i2c_stop();
        settle();
        chk("busy_stop", busy, 0);
        check_writes();
        chk("rd_addr_w", rd_addr, ref_ptr);
        if (!match) chk("oe_quiet", oe_cnt - oe0, 0);
    endtask

    task automatic txn_read(input logic [7:0] ptr, input int n);
        logic       nack;
        logic [7:0] d;
        int         rd0;
        rd0 = rd_cnt;
        i2c_start();
        write_byte({7'h49, 1'b0}, nack);
        chk("raddr_w_ack", nack, 0);
        write_byte(ptr, nack);
        chk("rptr_ack", nack, 0);
        ref_ptr = ptr[3:0];
        i2c_start();
        write_byte({7'h49, 1'b1}, nack);
        chk("raddr_r_ack", nack, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(d);
            chk("rd_byte", d, ref_mem[ref_ptr]);
            ref_ptr = ref_ptr + 4'd1;
            write_bit(i == n - 1);
        end
        i2c_stop();
        settle();
        chk("rd_addr_r", rd_addr, ref_ptr);
        chk("rd_en_cnt", rd_cnt - rd0, n);
        chk("busy_rstop", busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_oe"}, sda_oe, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic       nack;
        logic [6:0] a;
        int         kind;
        #22;
        check_reset_vals("rst");
        reset_n = 1'b1;
        settle();
        for (int i = 0; i < 16; i++) tb_set(i[3:0], 8'($urandom));

        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        txn_write(7'h49, 8'h03, 2);

        wbuf[0] = 8'h77; wbuf[1] = 8'h88;
        txn_write(7'h22, 8'h01, 2);

        tb_set(4'hE, 8'h11); tb_set(4'hF, 8'h22); tb_set(4'h0, 8'h33);
        txn_read(8'h0E, 3);
        chk("rd_addr_end", rd_addr, 1);

        wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
        txn_write(7'h49, 8'hFF, 2);

        // STOP after four data bits must discard the partial byte
        wq.delete();
        i2c_start();
        write_byte({7'h49, 1'b0}, nack);
        write_byte(8'h07, nack);
        ref_ptr = 4'h7;
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_stop();
        settle();
        chk("partial_wr", wq.size(), 0);
        chk("partial_busy", busy, 0);
        chk("partial_ptr", rd_addr, ref_ptr);
        wbuf[0] = 8'h5E;
        txn_write(7'h49, 8'h09, 1);

        // Reset while the target drives a 0 data bit
        tb_set(4'h5, 8'h00);
        i2c_start();
        write_byte({7'h49, 1'b0}, nack);
        write_byte(8'h05, nack);
        i2c_start();
        write_byte({7'h49, 1'b1}, nack);
        for (int i = 0; i < 200 && !sda_oe; i++) @(posedge clock);
        #1;
        chk("oe_before_rst", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        sda_m = 1'b1;
        #50;
        reset_n = 1'b1;
        #Q; scl_m = 1'b1; #Q;
        settle();
        ref_ptr = 4'h0;
        chk("post_rst_ptr", rd_addr, ref_ptr);
        wbuf[0] = 8'h9C; wbuf[1] = 8'h1D;
        txn_write(7'h49, 8'h0C, 2);
        txn_read(8'h0C, 2);

        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            if (kind <= 1) begin
                txn_write(7'h49, 8'($urandom), $urandom_range(1, 3));
            end else if (kind == 2) begin
                txn_read(8'($urandom), $urandom_range(1, 3));
            end else begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h49) a = 7'h22;
                txn_write(a, 8'($urandom), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
